pe_mc_mac: RTL
==============

// Module: pe_mc_mac
// PURPOSE
// Parametrised multi-channel convolution PE. Holds a KDEPTH-tap kernel per channel, multiplies streamed
// window pixels against it, and accumulates each channel over one window. At window end it sums the
// channels, then shifts and saturates or truncates the result into one output pixel.
// Sits between the window shift buffers and the output feature-map writer; replaces the fixed 1- and 4-channel PEs.
// PARAMETERS
// CH      4   channel count (lanes), >=1
// DW      8   pixel/kernel width, unsigned
// KDEPTH  16  taps per window per channel, >=2
// SHIFT   4   right shift applied to channel sum before output
// SAT_EN  1   1: saturate output to 2^DW-1; 0: truncate to low DW bits
// PORTS
// clk       input   1              clock, rising edge
// rst       input   1              asynchronous active-low reset
// ld_en     input   1              kernel tap write strobe
// ld_bcast  input   1              1: write tap to all channels, ignore ld_ch
// ld_ch     input   clog2(CH)      target channel for kernel write
// ld_addr   input   clog2(KDEPTH)  tap index
// ld_data   input   DW             tap value
// in_valid  input   1              window beat valid
// in_ready  output  1              PE accepts beat
// in_pix    input   CH*DW          one pixel per channel, ch0 in LSBs
// out_valid output  1              result valid
// out_ready input   1              consumer accepts result
// out_data  output  DW             output pixel
// busy      output  1              state != IDLE
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE; tap counter 0; all kernel taps 0; accumulators 0;
//   out_valid=0, out_data=0, busy=0; in_ready=1 after release.
// - FSM: IDLE -beat-> ACCUM -last beat-> SUM -1 cycle-> OUT -out_ready-> IDLE.
//   A beat is accepted when in_valid&&in_ready. in_ready=1 in IDLE/ACCUM, 0 in SUM/OUT.
// - Tap counter k increments per accepted beat. The beat with k==KDEPTH-1 is the last; k wraps to 0.
//   With KDEPTH taps, IDLE->ACCUM happens on beat 0 (acc_c <= product, not acc+product).
// - Lane c per beat: acc_c += kern_c[k] * in_pix[c]. Product width 2*DW. ACCW=2*DW+clog2(KDEPTH): no overflow.
// - SUM: total = sum of acc_c, width ACCW+clog2(CH), lossless. s = total >> SHIFT.
//   out_data <= SAT_EN && |s[hi:DW] ? {DW{1'b1}} : s[DW-1:0]. Lanes are then cleared.
// - Latency: out_valid rises on the 2nd rising edge after the edge accepting the last beat.
// - OUT: out_valid and out_data hold stable until out_ready. Handshake edge -> IDLE, out_valid=0.
//   In OUT with out_ready=1 the next beat is not accepted in the same cycle (no bypass).
// - Kernel load: written on edge when ld_en && state==IDLE. ld_en outside IDLE is ignored:
//   no write, no stall. ld_addr>=KDEPTH or ld_ch>=CH (non-bcast) is ignored.
//   A load and a beat 0 in the same IDLE cycle: the write lands; beat 0 uses the OLD tap value (read-before-write).
// - Reset mid-ACCUM/OUT: partial window discarded and kernel cleared; no out_valid afterwards.
// STRUCTURE
// - package pe_pkg: state encoding (IDLE/ACCUM/SUM/OUT), width helpers acc_w(DW,KDEPTH), sum_w(...).
// - sub-module pe_lane (one per channel, generate loop): KDEPTH x DW kernel regs, multiplier, accumulator, clear.
// - Top: FSM, tap counter, load decode, channel adder tree, shift/saturate, output register.
// TESTING
// 1 Reset values: rst low mid-ACCUM -> out_valid=0, busy=0, in_ready=1; next window with kernel never reloaded -> out_data=0.
// 2 All taps=1 (bcast), 16 beats in_pix=1 per ch -> total=64, out_data=4, out_valid exactly 2 edges after last beat.
// 3 All taps=255, in_pix=255, SAT_EN=1 -> out_data=255. Rebuild with SAT_EN=0 -> out_data=4 (260100 mod 256).
// 4 Backpressure: out_ready=0 for 5 cycles -> out_data stable, in_ready=0, in_valid beats not consumed; then handshake -> IDLE.
// 5 ld_en pulse during ACCUM (ch2,addr3,=9) -> tap unchanged. Same write in IDLE -> tap=9. Bcast write updates all 4 lanes.
// 6 in_valid gaps: 16 beats spread with random idle cycles -> same result as back-to-back; per-channel kernel 1,2,3,4 with pix=1 -> 160>>4=10.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared definitions for the multi-channel convolution PE.
//   peState_e : controller states
//   accW      : lane accumulator width, lossless over one window
//   sumW      : channel-sum width, lossless over all lanes
//   idxW      : index width that stays >=1 bit for single-entry ranges
package pe_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, SUM, OUT} peState_e;

  function automatic int accW(input int dw, input int kd);
    return 2*dw + $clog2(kd);
  endfunction

  function automatic int sumW(input int dw, input int kd, input int ch);
    return accW(dw, kd) + $clog2(ch);
  endfunction

  function automatic int idxW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pe_lane.sv
// One channel of the PE: KDEPTH-tap kernel store, multiplier and window
// accumulator.
//   wrEn/wrAddr/wrData : kernel tap write (already qualified by the top)
//   beat/first/tap/pix : accepted window beat, first-beat flag, tap index, pixel
//   clr                : drop the accumulator after the channel sum is taken
//   acc                : running window accumulation
module pe_lane #(
  parameter int DW     = 8,
  parameter int KDEPTH = 16,
  parameter int ACCW   = 20,
  parameter int KW     = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wrEn,
  input  logic [KW-1:0]   wrAddr,
  input  logic [DW-1:0]   wrData,
  input  logic            beat,
  input  logic            first,
  input  logic [KW-1:0]   tap,
  input  logic [DW-1:0]   pix,
  input  logic            clr,
  output logic [ACCW-1:0] acc
);

  logic [KDEPTH-1:0][DW-1:0] kern;
  logic [2*DW-1:0]           prod;

  // Product reads the registered tap, so a same-cycle write is seen only
  // by later beats.
  assign prod = (2*DW)'(kern[tap]) * (2*DW)'(pix);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      kern <= '0;
    else if (wrEn) kern[wrAddr] <= wrData;
  end

  // Beat 0 overwrites rather than adds, so a stale sum can never leak in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      acc <= '0;
    else if (clr)  acc <= '0;
    else if (beat) acc <= first ? ACCW'(prod) : acc + ACCW'(prod);
  end

endmodule

// File: rtl/pe_mc_mac.sv
// Multi-channel convolution PE. Streams KDEPTH window beats through CH lanes,
// sums the lanes at window end, shifts and saturates/truncates to one pixel.
//   ld_*      : kernel tap load (IDLE only; ld_bcast writes every lane)
//   in_*      : window beat handshake, one DW pixel per channel, ch0 in LSBs
//   out_*     : result handshake, held until out_ready
//   busy      : controller not idle
module pe_mc_mac
  import pe_pkg::*;
#(
  parameter int CH     = 4,
  parameter int DW     = 8,
  parameter int KDEPTH = 16,
  parameter int SHIFT  = 4,
  parameter int SAT_EN = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld_en,
  input  logic                    ld_bcast,
  input  logic [idxW(CH)-1:0]     ld_ch,
  input  logic [idxW(KDEPTH)-1:0] ld_addr,
  input  logic [DW-1:0]           ld_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CH*DW-1:0]        in_pix,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DW-1:0]           out_data,
  output logic                    busy
);

  localparam int ACCW = accW(DW, KDEPTH);
  localparam int SW   = sumW(DW, KDEPTH, CH);
  localparam int KW   = idxW(KDEPTH);

  peState_e               state, stateNxt;
  logic [KW-1:0]          k;
  logic                   beat, lastBeat, ldOk;
  logic [CH-1:0]          wrEn;
  logic [CH-1:0][ACCW-1:0] acc;
  logic [SW-1:0]          total, sumReg, shifted;
  logic [DW-1:0]          resPix;

  assign in_ready = (state == IDLE) || (state == ACCUM);
  assign busy     = (state != IDLE);
  assign beat     = in_valid && in_ready;
  assign lastBeat = beat && (k == KW'(KDEPTH - 1));
  assign ldOk     = ld_en && (state == IDLE) && (int'(ld_addr) < KDEPTH);

  for (genvar c = 0; c < CH; c++) begin : gLane
    // Out-of-range ld_ch matches no lane, so it is dropped here.
    assign wrEn[c] = ldOk && (ld_bcast || (int'(ld_ch) == c));

    pe_lane #(.DW(DW), .KDEPTH(KDEPTH), .ACCW(ACCW), .KW(KW)) uLane (
      .clk   (clk),
      .rst   (rst),
      .wrEn  (wrEn[c]),
      .wrAddr(ld_addr),
      .wrData(ld_data),
      .beat  (beat),
      .first (k == '0),
      .tap   (k),
      .pix   (in_pix[c*DW +: DW]),
      .clr   (state == SUM),
      .acc   (acc[c])
    );
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (beat)                   stateNxt = ACCUM;
      ACCUM:   if (lastBeat)               stateNxt = SUM;
      SUM:                                 stateNxt = OUT;
      OUT:     if (out_valid && out_ready) stateNxt = IDLE;
      default:                             stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= stateNxt;
      if (beat) k <= lastBeat ? '0 : k + KW'(1);
    end
  end

  always_comb begin
    total = '0;
    for (int c = 0; c < CH; c++) total = total + SW'(acc[c]);
  end

  assign shifted = sumReg >> SHIFT;
  assign resPix  = ((SAT_EN != 0) && (|shifted[SW-1:DW])) ? '1 : shifted[DW-1:0];

  // Two result stages: channel sum registered in SUM, shift/saturate
  // registered on the first OUT cycle, where out_valid rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sumReg    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (state == SUM) sumReg <= total;
      if (state == OUT && !out_valid) begin
        out_valid <= 1'b1;
        out_data  <= resPix;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
